// File: rtl/uart_tx_cfg.sv
// UART transmitter with a small push FIFO; data length, parity and stop bits are latched per frame.
// States: IDLE line idle | START start bit | DATA data bits | PARITY parity bit | STOP stop bit(s)
module uart_tx_cfg #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         timer_done,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         tx_enable,
  input  logic [$clog2(DATA_W+1)-1:0]  data_len,
  input  logic [1:0]                   parity_mode,
  input  logic                         stop_bits,
  output logic                         data_out,
  output logic                         tx_done,
  output logic                         busy,
  output logic                         fifo_full,
  output logic                         fifo_empty,
  output logic                         overflow
);
  localparam int LW = $clog2(DATA_W + 1);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [LW-1:0] LEN_MAX   = LW'(DATA_W);
  localparam logic [TW-1:0] TICK_LOAD = TW'(OVERSAMPLE - 1);
  localparam logic [AW:0]   DEPTH_V   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_overflow;
  logic              w_push, w_pop, w_load;

  state_t            r_state, w_state_nxt;
  logic [TW-1:0]     r_tick, w_tick_nxt;
  logic [LW-1:0]     r_bits_left, w_bits_left_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_par, w_par_nxt;
  logic [1:0]        r_pmode, w_pmode_nxt;
  logic              r_stop2, w_stop2_nxt;
  logic              r_data_out, w_data_out_nxt;
  logic              r_tx_done, w_tx_done_nxt;
  logic              w_bit_end, w_can_load, w_par_on;
  logic [LW-1:0]     w_len_eff;

  assign fifo_full  = (r_count == DEPTH_V);
  assign fifo_empty = (r_count == '0);
  assign w_push     = wr_en && !fifo_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_en && fifo_full;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

  assign w_len_eff  = (data_len == '0 || data_len > LEN_MAX) ? LEN_MAX : data_len;
  assign w_bit_end  = timer_done && (r_tick == '0);
  assign w_can_load = tx_enable && !fifo_empty;
  assign w_par_on   = r_pmode[0] ^ r_pmode[1];

  always_comb begin
    w_state_nxt     = r_state;
    w_tick_nxt      = r_tick;
    w_bits_left_nxt = r_bits_left;
    w_shift_nxt     = r_shift;
    w_par_nxt       = r_par;
    w_pmode_nxt     = r_pmode;
    w_stop2_nxt     = r_stop2;
    w_data_out_nxt  = r_data_out;
    w_tx_done_nxt   = 1'b0;
    w_load          = 1'b0;
    w_pop           = 1'b0;
    if (r_state != S_IDLE && timer_done)
      w_tick_nxt = (r_tick == '0) ? TICK_LOAD : r_tick - 1'b1;
    case (r_state)
      S_IDLE: begin
        w_data_out_nxt = 1'b1;
        if (w_can_load) w_load = 1'b1;
      end
      S_START: if (w_bit_end) begin
        w_state_nxt    = S_DATA;
        w_data_out_nxt = r_shift[0];
      end
      S_DATA: if (w_bit_end) begin
        w_par_nxt       = r_par ^ r_shift[0];
        w_shift_nxt     = r_shift >> 1;
        w_bits_left_nxt = r_bits_left - 1'b1;
        if (r_bits_left == LW'(1)) begin
          if (w_par_on) begin
            w_state_nxt    = S_PARITY;
            w_data_out_nxt = w_par_nxt ^ r_pmode[1];
          end else begin
            w_state_nxt     = S_STOP;
            w_data_out_nxt  = 1'b1;
            w_bits_left_nxt = LW'(r_stop2);
          end
        end else begin
          w_data_out_nxt = r_shift[1];
        end
      end
      S_PARITY: if (w_bit_end) begin
        w_state_nxt     = S_STOP;
        w_data_out_nxt  = 1'b1;
        w_bits_left_nxt = LW'(r_stop2);
      end
      // bits_left counts extra stop periods still owed
      S_STOP: if (w_bit_end) begin
        if (r_bits_left != '0) begin
          w_bits_left_nxt = r_bits_left - 1'b1;
        end else begin
          w_tx_done_nxt = 1'b1;
          if (w_can_load) w_load = 1'b1;
          else            w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_load) begin
      w_pop           = 1'b1;
      w_state_nxt     = S_START;
      w_data_out_nxt  = 1'b0;
      w_shift_nxt     = r_mem[r_rd_ptr];
      w_bits_left_nxt = w_len_eff;
      w_par_nxt       = 1'b0;
      w_pmode_nxt     = parity_mode;
      w_stop2_nxt     = stop_bits;
      w_tick_nxt      = TICK_LOAD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tick      <= '0;
      r_bits_left <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_pmode     <= 2'b00;
      r_stop2     <= 1'b0;
      r_data_out  <= 1'b1;
      r_tx_done   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick      <= w_tick_nxt;
      r_bits_left <= w_bits_left_nxt;
      r_shift     <= w_shift_nxt;
      r_par       <= w_par_nxt;
      r_pmode     <= w_pmode_nxt;
      r_stop2     <= w_stop2_nxt;
      r_data_out  <= w_data_out_nxt;
      r_tx_done   <= w_tx_done_nxt;
    end
  end

  assign data_out = r_data_out;
  assign tx_done  = r_tx_done;
  assign busy     = (r_state != S_IDLE);
  assign overflow = r_overflow;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: a queue-based frame model checked every clock, plus literal frame checks.
module tb_uart_tx_cfg;
  localparam int DATA_W = 8;
  localparam int OVERSAMPLE = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int LW = $clog2(DATA_W + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              timer_done = 1'b0;
  logic              wr_en = 1'b0;
  logic              tx_enable = 1'b0;
  logic              stop_bits = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [LW-1:0]     data_len = LW'(8);
  logic [1:0]        parity_mode = 2'b00;
  logic              data_out, tx_done, busy, fifo_full, fifo_empty, overflow;

  int checks = 0;
  int errors = 0;
  int tick_mode = 1;
  int tick_ph = 0;

  uart_tx_cfg #(.DATA_W(DATA_W), .OVERSAMPLE(OVERSAMPLE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .timer_done(timer_done), .wr_en(wr_en), .data_in(data_in),
    .tx_enable(tx_enable), .data_len(data_len), .parity_mode(parity_mode), .stop_bits(stop_bits),
    .data_out(data_out), .tx_done(tx_done), .busy(busy), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tick_ph = (tick_ph + 1 >= tick_mode) ? 0 : tick_ph + 1;
    timer_done = (tick_ph == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO as a queue, current frame as a list of bit-period levels.
  bit                m_bits[$];
  logic [DATA_W-1:0] m_fifo[$];
  bit                m_active = 1'b0;
  int                m_cnt = 0;
  logic              e_line = 1'b1, e_done = 1'b0, e_ovf = 1'b0;
  logic [DATA_W-1:0] m_w;
  int                m_n0, m_len;
  bit                m_p;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_bits.delete(); m_fifo.delete();
      m_active = 1'b0; m_cnt = 0;
      e_line = 1'b1; e_done = 1'b0; e_ovf = 1'b0;
    end else begin
      e_done = 1'b0; e_ovf = 1'b0;
      if (m_active && timer_done) begin
        m_cnt++;
        if (m_cnt == OVERSAMPLE) begin
          m_cnt = 0;
          void'(m_bits.pop_front());
          if (m_bits.size() == 0) begin m_active = 1'b0; e_done = 1'b1; end
        end
      end
      m_n0 = m_fifo.size();
      if (!m_active && tx_enable && m_n0 > 0) begin
        m_w = m_fifo.pop_front();
        m_len = (data_len == 0 || int'(data_len) > DATA_W) ? DATA_W : int'(data_len);
        m_bits.push_back(1'b0);
        m_p = 1'b0;
        for (int i = 0; i < m_len; i++) begin m_bits.push_back(m_w[i]); m_p ^= m_w[i]; end
        if (parity_mode == 2'b01) m_bits.push_back(m_p);
        else if (parity_mode == 2'b10) m_bits.push_back(!m_p);
        m_bits.push_back(1'b1);
        if (stop_bits) m_bits.push_back(1'b1);
        m_active = 1'b1; m_cnt = 0;
      end
      if (wr_en) begin
        if (m_n0 >= FIFO_DEPTH) e_ovf = 1'b1;
        else m_fifo.push_back(data_in);
      end
      e_line = m_active ? m_bits[0] : 1'b1;
    end
  end

  always @(posedge clk) begin
    #2;
    chk("data_out", data_out, e_line);
    chk("tx_done", tx_done, e_done);
    chk("busy", busy, m_active);
    chk("fifo_full", fifo_full, m_fifo.size() == FIFO_DEPTH);
    chk("fifo_empty", fifo_empty, m_fifo.size() == 0);
    chk("overflow", overflow, e_ovf);
  end

  task automatic push(input logic [DATA_W-1:0] w);
    data_in = w; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic capture(input int per_bit, input int nbits, output logic [15:0] bits, output int cycles);
    int t;
    t = 0; bits = '0; cycles = 0;
    while (data_out !== 1'b0 && t < 1000) begin @(negedge clk); t++; end
    chk("frame_start_seen", t < 1000, 1);
    while (tx_done !== 1'b1 && cycles < 3000) begin
      if ((cycles % per_bit) == per_bit / 2 && cycles / per_bit < nbits) bits[cycles / per_bit] = data_out;
      @(negedge clk); cycles++;
    end
    @(negedge clk);
    chk("tx_done_one_clock", tx_done, 0);
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (data_out === lvl && n < 2000) begin @(negedge clk); n++; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits;
    int cyc, n, dn, idle;
    bit started;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_data_out", data_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_empty", fifo_empty, 1);
    chk("rst_fifo_full", fifo_full, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_overflow", overflow, 0);

    tx_enable = 1'b1;
    push(8'hA5); capture(16, 10, bits, cyc);
    chk("8n1_bits", bits, 16'h034A); chk("8n1_ticks", cyc, 160);

    parity_mode = 2'b01;
    push(8'hA5); capture(16, 11, bits, cyc);
    chk("even_bits", bits, 16'h054A); chk("even_ticks", cyc, 176);

    parity_mode = 2'b10;
    push(8'hA5); capture(16, 11, bits, cyc);
    chk("odd_bits", bits, 16'h074A); chk("odd_ticks", cyc, 176);

    parity_mode = 2'b00; data_len = LW'(7); stop_bits = 1'b1;
    push(8'hFF); capture(16, 10, bits, cyc);
    chk("len7_bits", bits, 16'h03FE); chk("len7_ticks", cyc, 160);
    data_len = LW'(8); stop_bits = 1'b0;

    tx_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_in = 8'(17 * (i + 1)); wr_en = 1'b1;
      @(negedge clk);
      if (i == 2) chk("not_full_at_3", fifo_full, 0);
      if (i == 3) chk("full_after_4", fifo_full, 1);
      if (i == 4) chk("overflow_on_5th", overflow, 1);
    end
    wr_en = 1'b0;
    @(negedge clk);
    chk("overflow_one_clock", overflow, 0);

    tx_enable = 1'b1; dn = 0; idle = 0; started = 1'b0; n = 0;
    while (dn < 4 && n < 2000) begin
      @(negedge clk); n++;
      if (n == 50) begin data_len = LW'(6); parity_mode = 2'b10; end
      if (tx_done) dn++;
      if (dn < 4) begin
        if (started && !busy) idle++;
        if (busy) started = 1'b1;
      end
    end
    chk("b2b_done_count", dn, 4);
    chk("b2b_idle_clocks", idle, 0);
    chk("b2b_total_clocks", n, 593);
    chk("b2b_empty_after", fifo_empty, 1);
    data_len = LW'(8); parity_mode = 2'b00;

    push(8'h3C); push(8'hC3);
    repeat (30) @(negedge clk);
    tx_enable = 1'b0; dn = 0;
    repeat (300) begin @(negedge clk); if (tx_done) dn++; end
    chk("drop_done_count", dn, 1);
    chk("drop_idle", busy, 0);
    chk("drop_word_kept", fifo_empty, 0);
    tx_enable = 1'b1;
    repeat (200) @(negedge clk);
    chk("drop_drained", fifo_empty, 1);

    tick_mode = 3;
    push(8'hA5);
    run_len(1'b1, n);
    run_len(1'b0, n);
    run_len(1'b1, n); chk("tick3_bit0_clocks", n, 48);
    run_len(1'b0, n); chk("tick3_bit1_clocks", n, 48);
    run_len(1'b1, n); chk("tick3_bit2_clocks", n, 48);
    run_len(1'b0, n); chk("tick3_bit34_clocks", n, 96);
    n = 0;
    while (tx_done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    chk("tick3_done_seen", n < 2000, 1);
    tick_mode = 1;
    repeat (3) @(negedge clk);

    push(8'h3C); push(8'h5A);
    run_len(1'b1, n);
    repeat (40) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("arst_data_out", data_out, 1);
    chk("arst_busy", busy, 0);
    chk("arst_fifo_empty", fifo_empty, 1);
    chk("arst_fifo_full", fifo_full, 0);
    chk("arst_tx_done", tx_done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0; dn = 0;
    repeat (60) begin @(negedge clk); if (tx_done) dn++; end
    chk("arst_no_tx_done", dn, 0);
    chk("arst_idle_line", data_out, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
